// File: rtl/prog_mem_reader.sv
// Program-memory read-back unit: walks every word from address 0 to the last one and
// hands each {opcode,immediate} to the host over a 4-phase valid/ack handshake.
module prog_mem_reader #(
    parameter int ADDR_W       = 4,
    parameter int READ_LATENCY = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [3:0]        mem_opcode,
    input  logic [3:0]        mem_immediate,
    output logic [7:0]        dout,
    output logic              dout_valid,
    input  logic              ack_in,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RD,
        S_PRESENT,
        S_WAIT_ACK_HI,
        S_WAIT_ACK_LO,
        S_FIN
    } state_t;

    localparam logic [1:0] LAT = 2'(READ_LATENCY);

    state_t                 r_state;
    state_t                 w_next;
    logic [ADDR_W-1:0]      r_addr;
    logic [1:0]             r_lat_cnt;
    logic [7:0]             r_dout;
    logic                   r_dout_valid;
    logic                   r_start_d;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   w_last;
    logic                   w_start_rise;

    assign w_ack_s      = r_ack_sync[SYNC_STAGES-1];
    assign w_last       = &r_addr;
    // A held start must not retrigger a dump once the previous one finishes.
    assign w_start_rise = start & ~r_start_d;

    // NOTE: state and datapath registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        if (w_start_rise) w_next = S_ISSUE;
            S_ISSUE:       w_next = S_WAIT_RD;
            S_WAIT_RD:     if (r_lat_cnt == 2'd1) w_next = S_PRESENT;
            S_PRESENT:     if (!w_ack_s) w_next = S_WAIT_ACK_HI;
            S_WAIT_ACK_HI: if (w_ack_s) w_next = S_WAIT_ACK_LO;
            S_WAIT_ACK_LO: if (!w_ack_s) w_next = w_last ? S_FIN : S_ISSUE;
            S_FIN:         w_next = S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_lat_cnt    <= '0;
            r_dout       <= 8'h00;
            r_dout_valid <= 1'b0;
            r_start_d    <= 1'b0;
            r_ack_sync   <= '0;
        end else begin
            r_start_d  <= start;
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_in};
            case (r_state)
                S_IDLE: begin
                    if (w_start_rise) r_addr <= '0;
                end
                S_ISSUE: begin
                    r_lat_cnt <= LAT;
                end
                S_WAIT_RD: begin
                    // Last count cycle is the one where memory data is valid.
                    if (r_lat_cnt == 2'd1) r_dout <= {mem_opcode, mem_immediate};
                    else                   r_lat_cnt <= r_lat_cnt - 2'd1;
                end
                S_PRESENT: begin
                    if (!w_ack_s) r_dout_valid <= 1'b1;
                end
                S_WAIT_ACK_HI: begin
                    if (w_ack_s) r_dout_valid <= 1'b0;
                end
                S_WAIT_ACK_LO: begin
                    if (!w_ack_s && !w_last) r_addr <= r_addr + 1'b1;
                end
                S_FIN: begin
                    r_addr <= '0;
                end
                default: begin
                    r_addr <= '0;
                end
            endcase
        end
    end

    assign mem_addr   = r_addr;
    assign mem_rd_en  = (r_state == S_ISSUE);
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_FIN);

endmodule
